// File: rtl/timer_periph.sv
// Bus-mapped 32-bit timer: prescaled counter with compare match,
// optional auto-reload, sticky pending flag and level interrupt.
// Register map on addr[4:2]: 0 CTRL, 1 COUNT, 2 COMPARE, 3 PRESCALE, 4 STATUS.
module timer_periph #(
   parameter int          PRE_W   = 16,
   parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  sel,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        timer_irq_o
);

   typedef enum logic [2:0] {
      REG_CTRL     = 3'd0,
      REG_COUNT    = 3'd1,
      REG_COMPARE  = 3'd2,
      REG_PRESCALE = 3'd3,
      REG_STATUS   = 3'd4
   } reg_e;

   logic             en;
   logic             auto_rl;
   logic             ie;
   logic [31:0]      count;
   logic [31:0]      compare;
   logic [PRE_W-1:0] prescale;
   logic [PRE_W-1:0] pre_cnt;
   logic             pend;

   logic [2:0]       reg_idx;
   logic             wr;
   logic             wr_ctrl;
   logic             wr_count;
   logic             wr_compare;
   logic             wr_prescale;
   logic             wr_status;
   logic             tick;
   logic             match;
   logic [PRE_W-1:0] prescale_wr;
   logic             unused_addr;

   assign reg_idx     = addr[4:2];
   assign unused_addr = ^{addr[31:5], addr[1:0]};
   assign wr          = ce & we;
   assign wr_ctrl     = wr && (reg_idx == REG_CTRL);
   assign wr_count    = wr && (reg_idx == REG_COUNT);
   assign wr_compare  = wr && (reg_idx == REG_COMPARE);
   assign wr_prescale = wr && (reg_idx == REG_PRESCALE);
   assign wr_status   = wr && (reg_idx == REG_STATUS);

   // A tick fires when the prescaler reaches PRESCALE; a match also needs COUNT==COMPARE.
   assign tick  = en && (pre_cnt == prescale);
   assign match = tick && (count == compare);

   // Interrupt is a pure function of flops, so the bus cannot glitch it.
   assign timer_irq_o = pend & ie;

   // Replace only the byte lanes enabled by sel.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (lanes[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   // Byte-lane merge for the narrower PRESCALE register.
   always_comb begin
      prescale_wr = prescale;
      for (int i = 0; i < PRE_W; i++) begin
         if (sel[i/8]) prescale_wr[i] = data_i[i];
      end
   end

   // Control bits and the plain configuration registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en       <= 1'b0;
         auto_rl  <= 1'b0;
         ie       <= 1'b0;
         compare  <= CMP_RST;
         prescale <= '0;
      end else begin
         if (wr_ctrl && sel[0]) begin
            en      <= data_i[0];
            auto_rl <= data_i[1];
            ie      <= data_i[2];
         end
         if (wr_compare)  compare  <= merge_bytes(compare, data_i, sel);
         if (wr_prescale) prescale <= prescale_wr;
      end
   end

   // Prescaler: held at zero while disabled or when EN is being written to 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_cnt <= '0;
      end else if (!en || (wr_ctrl && sel[0] && !data_i[0])) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // Main counter: a bus write beats the tick's increment or reload.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (wr_count) begin
         count <= merge_bytes(count, data_i, sel);
      end else if (tick) begin
         count <= (match && auto_rl) ? 32'd0 : count + 32'd1;
      end
   end

   // Pending flag: a new match beats a simultaneous write-1-to-clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend <= 1'b0;
      end else if (match) begin
         pend <= 1'b1;
      end else if (wr_status && sel[0] && data_i[0]) begin
         pend <= 1'b0;
      end
   end

   // Combinational read mux, zero when not reading.
   always_comb begin
      data_o = 32'h0;
      if (ce && !we) begin
         case (reg_idx)
            REG_CTRL:     data_o = {29'h0, ie, auto_rl, en};
            REG_COUNT:    data_o = count;
            REG_COMPARE:  data_o = compare;
            REG_PRESCALE: data_o = 32'(prescale);
            REG_STATUS:   data_o = {31'h0, pend};
            default:      data_o = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_periph.sv
// Self-checking bench for timer_periph: table of register accesses
// followed by hand-written multi-cycle timing sequences.
module tb_timer_periph;

   logic        clk;
   logic        rst;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        timer_irq_o;

   int total;
   int bad;

   typedef struct {
      logic        wr;
      logic [2:0]  idx;
      logic [3:0]  sel;
      logic [31:0] data;
      logic [31:0] exp_data;
      string       name;
   } vec_t;

   vec_t vecs[27];

   timer_periph #(.PRE_W(16), .CMP_RST(32'hFFFF_FFFF)) dut (
      .clk         (clk),
      .rst         (rst),
      .ce          (ce),
      .we          (we),
      .addr        (addr),
      .sel         (sel),
      .data_i      (data_i),
      .data_o      (data_o),
      .timer_irq_o (timer_irq_o)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // One clock cycle with the given bus request; returns 1 unit after the edge.
   task automatic applyStimulus(input logic c, input logic w, input logic [2:0] idx,
                                input logic [3:0] s, input logic [31:0] d);
      ce     = c;
      we     = w;
      addr   = {27'h0, idx, 2'b00};
      sel    = s;
      data_i = d;
      @(posedge clk);
      #1;
      ce     = 1'b0;
      we     = 1'b0;
      sel    = 4'h0;
      data_i = 32'h0;
   endtask

   task automatic writeReg(input logic [2:0] idx, input logic [31:0] d);
      applyStimulus(1'b1, 1'b1, idx, 4'hF, d);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
   endtask

   // Combinational read within the current cycle, no edge consumed.
   task automatic readReg(input logic [2:0] idx, output logic [31:0] v);
      ce   = 1'b1;
      we   = 1'b0;
      addr = {27'h0, idx, 2'b00};
      #1;
      v    = data_o;
      ce   = 1'b0;
   endtask

   task automatic checkReg(input string name, input logic [2:0] idx,
                           input logic [31:0] expected);
      logic [31:0] v;
      readReg(idx, v);
      checkOutput(name, v, expected);
   endtask

   initial begin
      logic [31:0] exp_cnt;
      logic        exp_pend;

      total  = 0;
      bad    = 0;
      rst    = 1'b0;
      ce     = 1'b0;
      we     = 1'b0;
      addr   = 32'h0;
      sel    = 4'h0;
      data_i = 32'h0;

      vecs[0]  = '{1'b0, 3'd0, 4'h0, 32'h0,         32'h0000_0000, "rst_ctrl"};
      vecs[1]  = '{1'b0, 3'd1, 4'h0, 32'h0,         32'h0000_0000, "rst_count"};
      vecs[2]  = '{1'b0, 3'd2, 4'h0, 32'h0,         32'hFFFF_FFFF, "rst_compare"};
      vecs[3]  = '{1'b0, 3'd3, 4'h0, 32'h0,         32'h0000_0000, "rst_prescale"};
      vecs[4]  = '{1'b0, 3'd4, 4'h0, 32'h0,         32'h0000_0000, "rst_status"};
      vecs[5]  = '{1'b0, 3'd5, 4'h0, 32'h0,         32'h0000_0000, "rst_addr5"};
      vecs[6]  = '{1'b0, 3'd6, 4'h0, 32'h0,         32'h0000_0000, "rst_addr6"};
      vecs[7]  = '{1'b0, 3'd7, 4'h0, 32'h0,         32'h0000_0000, "rst_addr7"};
      vecs[8]  = '{1'b1, 3'd2, 4'hF, 32'h1122_3344, 32'h0,         "wr_compare"};
      vecs[9]  = '{1'b1, 3'd2, 4'h2, 32'hAABB_CCDD, 32'h0,         "wr_compare_lane1"};
      vecs[10] = '{1'b0, 3'd2, 4'h0, 32'h0,         32'h1122_CC44, "compare_lanes"};
      vecs[11] = '{1'b1, 3'd3, 4'hF, 32'hFFFF_FFFF, 32'h0,         "wr_prescale"};
      vecs[12] = '{1'b0, 3'd3, 4'h0, 32'h0,         32'h0000_FFFF, "prescale_zext"};
      vecs[13] = '{1'b1, 3'd3, 4'h1, 32'h0000_0012, 32'h0,         "wr_prescale_lane0"};
      vecs[14] = '{1'b0, 3'd3, 4'h0, 32'h0,         32'h0000_FF12, "prescale_lane0"};
      vecs[15] = '{1'b1, 3'd3, 4'hF, 32'h0,         32'h0,         "wr_prescale_zero"};
      vecs[16] = '{1'b1, 3'd0, 4'hF, 32'hFFFF_FFF6, 32'h0,         "wr_ctrl"};
      vecs[17] = '{1'b0, 3'd0, 4'h0, 32'h0,         32'h0000_0006, "ctrl_bits"};
      vecs[18] = '{1'b1, 3'd0, 4'hE, 32'hFFFF_FFFF, 32'h0,         "wr_ctrl_nolane0"};
      vecs[19] = '{1'b0, 3'd0, 4'h0, 32'h0,         32'h0000_0006, "ctrl_lane_gate"};
      vecs[20] = '{1'b1, 3'd0, 4'hF, 32'h0,         32'h0,         "wr_ctrl_zero"};
      vecs[21] = '{1'b1, 3'd5, 4'hF, 32'hFFFF_FFFF, 32'h0,         "wr_addr5"};
      vecs[22] = '{1'b0, 3'd5, 4'h0, 32'h0,         32'h0000_0000, "addr5_ignored"};
      vecs[23] = '{1'b1, 3'd1, 4'h5, 32'h1234_5678, 32'h0,         "wr_count_lanes"};
      vecs[24] = '{1'b0, 3'd1, 4'h0, 32'h0,         32'h0034_0078, "count_lanes"};
      vecs[25] = '{1'b1, 3'd1, 4'hF, 32'h0,         32'h0,         "wr_count_zero"};
      vecs[26] = '{1'b0, 3'd1, 4'h0, 32'h0,         32'h0000_0000, "count_zero"};

      #22;
      checkOutput("rst_irq", {31'h0, timer_irq_o}, 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("idle_data_o", data_o, 32'h0);

      // Register access table; EN stays 0 so COUNT is static throughout.
      for (int i = 0; i < 27; i++) begin
         if (vecs[i].wr) begin
            applyStimulus(1'b1, 1'b1, vecs[i].idx, vecs[i].sel, vecs[i].data);
         end else begin
            checkReg(vecs[i].name, vecs[i].idx, vecs[i].exp_data);
            checkOutput({vecs[i].name, "_irq"}, {31'h0, timer_irq_o}, 32'h0);
         end
      end

      // One-shot: COMPARE=5, PRESCALE=0, EN|IE; match on the sixth edge.
      writeReg(3'd2, 32'd5);
      writeReg(3'd3, 32'd0);
      writeReg(3'd0, 32'h5);
      for (int k = 1; k <= 6; k++) begin
         idle();
         checkReg($sformatf("oneshot_count_%0d", k), 3'd1, 32'(k));
         checkReg($sformatf("oneshot_pend_%0d", k), 3'd4, (k == 6) ? 32'h1 : 32'h0);
         checkOutput($sformatf("oneshot_irq_%0d", k), {31'h0, timer_irq_o},
                     (k == 6) ? 32'h1 : 32'h0);
      end
      writeReg(3'd0, 32'h0);
      checkReg("oneshot_keeps_counting", 3'd1, 32'd7);
      writeReg(3'd4, 32'h1);
      checkReg("oneshot_cleared", 3'd4, 32'h0);
      checkReg("disabled_count_hold", 3'd1, 32'd7);
      checkOutput("oneshot_irq_off", {31'h0, timer_irq_o}, 32'h0);

      // Auto-reload with PRESCALE=1, plus W1C and COUNT-write collisions.
      writeReg(3'd1, 32'd0);
      writeReg(3'd2, 32'd3);
      writeReg(3'd3, 32'd1);
      writeReg(3'd0, 32'h7);
      for (int k = 1; k <= 26; k++) begin
         if (k == 9 || k == 24)
            writeReg(3'd4, 32'h1);
         else if (k == 26)
            writeReg(3'd1, 32'h10);
         else
            idle();
         exp_cnt  = (k == 26) ? 32'h10 : 32'((k / 2) % 4);
         exp_pend = (k == 8) || (k >= 16);
         checkReg($sformatf("auto_count_%0d", k), 3'd1, exp_cnt);
         checkReg($sformatf("auto_pend_%0d", k), 3'd4, {31'h0, exp_pend});
         checkOutput($sformatf("auto_irq_%0d", k), {31'h0, timer_irq_o}, {31'h0, exp_pend});
      end
      writeReg(3'd0, 32'h0);
      writeReg(3'd4, 32'h1);
      checkReg("auto_stop_count", 3'd1, 32'h10);
      checkReg("auto_stop_pend", 3'd4, 32'h0);

      // Wrap from all-ones with COMPARE=0, AUTO=0, IE=0.
      writeReg(3'd1, 32'hFFFF_FFFF);
      writeReg(3'd2, 32'h0);
      writeReg(3'd3, 32'h0);
      writeReg(3'd0, 32'h1);
      idle();
      checkReg("wrap_count", 3'd1, 32'h0);
      checkReg("wrap_no_pend", 3'd4, 32'h0);
      idle();
      checkReg("wrap_match_count", 3'd1, 32'h1);
      checkReg("wrap_match_pend", 3'd4, 32'h1);
      checkOutput("wrap_irq_masked", {31'h0, timer_irq_o}, 32'h0);
      writeReg(3'd0, 32'h5);
      checkOutput("irq_enabled", {31'h0, timer_irq_o}, 32'h1);

      // Asynchronous reset pulsed between clock edges.
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_rst_irq", {31'h0, timer_irq_o}, 32'h0);
      checkReg("async_rst_ctrl", 3'd0, 32'h0);
      checkReg("async_rst_count", 3'd1, 32'h0);
      checkReg("async_rst_compare", 3'd2, 32'hFFFF_FFFF);
      checkReg("async_rst_status", 3'd4, 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      idle();
      idle();
      idle();
      checkReg("post_rst_count_hold", 3'd1, 32'h0);
      checkOutput("post_rst_irq", {31'h0, timer_irq_o}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timer_periph.md
TIMER_PERIPH -- requirements
Module: timer_periph

Interface
REQ-001 Parameter PRE_W, default 16, width of the prescaler register and the prescaler counter.
REQ-002 Parameter CMP_RST, default 32'hFFFF_FFFF, reset value of the COMPARE register.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ce  input  1  bus access strobe for this block.
REQ-006 we  input  1  write access when 1, read access when 0.
REQ-007 addr  input  32  byte address; only addr[4:2] is decoded.
REQ-008 sel  input  4  write byte enables; sel[i] enables data_i[8i+7:8i].
REQ-009 data_i  input  32  write data.
REQ-010 data_o  output  32  read data.
REQ-011 timer_irq_o  output  1  level interrupt request, routed to one bit of the CPU's 6-bit int_i.

Function
REQ-012 Register map on addr[4:2]:
- 0: CTRL. bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable); bits 31:3 read 0.
- 1: COUNT (32 bits).
- 2: COMPARE (32 bits).
- 3: PRESCALE (PRE_W bits, zero-extended on read).
- 4: STATUS. bit0 PEND, write-1-to-clear.
- 5-7: read 0; writes ignored.
REQ-013 Reads are combinational: data_o = selected register when ce=1 and we=0; otherwise data_o=32'h0.
REQ-014 Writes occur on the rising clk edge when ce=1 and we=1.
- Only byte lanes with sel[i]=1 are updated.
- Unimplemented bits are ignored.
REQ-015 Prescaler counter pre_cnt (PRE_W bits, not bus-visible):
- While EN=1 it increments each cycle.
- When pre_cnt==PRESCALE, pre_cnt returns to 0 and a one-cycle tick is generated.
- PRESCALE=0 therefore ticks every cycle.
REQ-016 While EN=0: pre_cnt is held at 0, no ticks occur, and COUNT holds its value.
REQ-017 On a tick with COUNT==COMPARE:
- PEND is set to 1.
- COUNT becomes 0 if AUTO=1, otherwise COUNT+1.
REQ-018 On a tick with COUNT!=COMPARE, COUNT becomes COUNT+1, wrapping 32'hFFFF_FFFF to 0 with no other side effect.
REQ-019 timer_irq_o = PEND & IE, derived only from flops, with no combinational path from bus inputs.
REQ-020 A bus write to COUNT in the same cycle as a tick takes precedence: COUNT takes the written bytes, and the tick's increment or reload is discarded for that cycle.
REQ-021 A match uses COUNT's pre-write value. A match in the same cycle as a COUNT write still sets PEND.
REQ-022 A STATUS write-1-to-clear in the same cycle as a new match leaves PEND=1 (set wins).
REQ-023 A write that changes PRESCALE does not reset pre_cnt.
- If the new PRESCALE is below pre_cnt, pre_cnt counts up to 2^PRE_W-1, wraps to 0, then matches normally.
REQ-024 Writing CTRL with EN=0 forces pre_cnt to 0 on that edge.
REQ-025 IE gates only timer_irq_o. PEND still sets when IE=0.

Reset
REQ-026 While rst=0, immediately and independent of clk:
- CTRL=0, COUNT=0, COMPARE=CMP_RST, PRESCALE=0, pre_cnt=0, PEND=0.
- timer_irq_o=0.
REQ-027 Reset asserted mid-count aborts counting. After release, counting resumes only once EN is written to 1.

Verification
REQ-028 Reset value check: after reset, read all addresses -> CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, PRESCALE=0, STATUS=0, addresses 5-7 read 0; timer_irq_o=0.
REQ-029 One-shot match: write COMPARE=5, PRESCALE=0, then CTRL=3'b101 -> PEND and timer_irq_o rise on the sixth edge after the CTRL write; COUNT reads 6, then keeps incrementing.
REQ-030 Auto-reload with prescaler:
- Stimulus: COMPARE=3, PRESCALE=1, CTRL=3'b111.
- Response: COUNT steps every 2 cycles through 0,1,2,3,0; PEND sets once per 8 cycles.
- Writing STATUS=1 clears PEND, then PEND re-sets at the next match.
REQ-031 Collisions:
- A STATUS W1C write coinciding with a match edge -> PEND stays 1.
- A COUNT write of 32'h10 coinciding with a tick -> COUNT reads 32'h10.
REQ-032 Byte lanes: with COMPARE=32'h1122_3344, write data_i=32'hAABB_CCDD with sel=4'b0010 -> COMPARE reads 32'h1122_CC44.
REQ-033 Wrap and async reset:
- COUNT=32'hFFFF_FFFF, COMPARE=0, AUTO=0, EN=1 -> the next tick gives COUNT=0 with no PEND; the tick after that sets PEND.
- rst pulsed low between clk edges -> all outputs zero immediately.
